des_key_rotor: RTL and testbench

- Iterative DES key-schedule rotation engine: takes the 28-bit C0/D0 halves (post PC-1) and streams all ROUNDS rotated pairs (Ci, Di), one per accepted handshake.
- Generalised successor of the single-shot rotator: parametrised width, round count and shift schedule.
- Adds a decrypt mode (reverse order, right rotations) and valid/ready backpressure.
- Sits between PC-1 and the PC-2/subkey store.

---
 rtl/des_key_rotor.sv | 148 ++++++++++++++
 tb/tb_des_key_rotor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/des_key_rotor.sv
// rtl/des_key_rotor.sv - iterative DES key-schedule rotation engine with encrypt/decrypt order and valid/ready output
module des_key_rotor #(
    parameter int                HALF_W    = 28,
    parameter int                ROUNDS    = 16,
    parameter logic [ROUNDS-1:0] SHIFT_MAP = 16'h7EFC,
    localparam int               CNT_W     = $clog2(ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [HALF_W-1:0] c_in,
    input  logic [HALF_W-1:0] d_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  round_idx,
    output logic [HALF_W-1:0] c_out,
    output logic [HALF_W-1:0] d_out,
    output logic              done
);

    // Net rotation accumulated over the whole schedule; the decrypt stream starts here.
    function automatic int calc_total();
        int acc;
        acc = 0;
        for (int r = 0; r < ROUNDS; r++) begin
            acc += SHIFT_MAP[r] ? 2 : 1;
        end
        return acc % HALF_W;
    endfunction

    localparam int                TOTAL     = calc_total();
    localparam logic [ROUNDS:0]   MAP_PAD   = {1'b0, SHIFT_MAP};
    localparam logic [CNT_W-1:0]  FIRST_IDX = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(ROUNDS);

    function automatic logic [HALF_W-1:0] rot_step(input logic [HALF_W-1:0] x,
                                                   input logic right, input logic two);
        logic [HALF_W-1:0] y;
        case ({right, two})
            2'b00:   y = {x[HALF_W-2:0], x[HALF_W-1]};
            2'b01:   y = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            2'b10:   y = {x[0], x[HALF_W-1:1]};
            default: y = {x[1:0], x[HALF_W-1:2]};
        endcase
        return y;
    endfunction

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mode;
    logic                r_done;
    logic [CNT_W-1:0]    r_idx;
    logic [HALF_W-1:0]   r_c;
    logic [HALF_W-1:0]   r_d;

    logic                w_hs;
    logic                w_last;
    logic                w_two;
    logic                w_load;
    logic [CNT_W-1:0]    w_idx_dn;
    logic [CNT_W-1:0]    w_idx_up;
    logic [2*HALF_W-1:0] w_c_dbl;
    logic [2*HALF_W-1:0] w_d_dbl;
    logic [HALF_W-1:0]   w_c_load;
    logic [HALF_W-1:0]   w_d_load;
    logic [HALF_W-1:0]   w_c_step;
    logic [HALF_W-1:0]   w_d_step;

    // Handshake, last-round detection and the per-round shift amount / next pair.
    always_comb begin
        w_hs     = (r_state == S_RUN) && out_ready;
        w_last   = r_mode ? (r_idx == FIRST_IDX) : (r_idx == LAST_IDX);
        w_idx_dn = r_idx - FIRST_IDX;
        w_idx_up = r_idx + FIRST_IDX;
        // Encrypt moves to round idx+1 (map bit idx); decrypt undoes round idx (map bit idx-1).
        w_two    = r_mode ? MAP_PAD[w_idx_dn] : MAP_PAD[r_idx];
        w_c_step = rot_step(r_c, r_mode, w_two);
        w_d_step = rot_step(r_d, r_mode, w_two);
        // Constant TOTAL rotation taken as a fixed slice of the doubled input.
        w_c_dbl  = {c_in, c_in};
        w_d_dbl  = {d_in, d_in};
        w_load   = (r_state == S_IDLE) && start;
        if (mode) begin
            w_c_load = w_c_dbl[2*HALF_W-1-TOTAL -: HALF_W];
            w_d_load = w_d_dbl[2*HALF_W-1-TOTAL -: HALF_W];
        end else begin
            w_c_load = rot_step(c_in, 1'b0, MAP_PAD[0]);
            w_d_load = rot_step(d_in, 1'b0, MAP_PAD[0]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> RUN on start, RUN -> IDLE on the final handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_hs && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load first pair on start, advance one round per handshake, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_done <= 1'b0;
            r_idx  <= '0;
            r_c    <= '0;
            r_d    <= '0;
        end else begin
            r_done <= w_hs && w_last;
            if (w_load) begin
                r_mode <= mode;
                r_idx  <= mode ? LAST_IDX : FIRST_IDX;
                r_c    <= w_c_load;
                r_d    <= w_d_load;
            end else if (w_hs && !w_last) begin
                r_idx  <= r_mode ? w_idx_dn : w_idx_up;
                r_c    <= w_c_step;
                r_d    <= w_d_step;
            end
        end
    end

    // Outputs decoded from state and datapath registers.
    always_comb begin
        busy      = (r_state == S_RUN);
        out_valid = (r_state == S_RUN);
        done      = r_done;
        round_idx = r_idx;
        c_out     = r_c;
        d_out     = r_d;
    end

endmodule

// File: tb/tb_des_key_rotor.sv
// tb/tb_des_key_rotor.sv - randomized self-checking bench for des_key_rotor against a cumulative-rotation model
module tb_des_key_rotor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full-size DES instance
    logic        rst, start, mode, out_ready;
    logic [27:0] c_in, d_in, c_out, d_out;
    logic        busy, out_valid, done;
    logic [4:0]  round_idx;

    des_key_rotor dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .c_in(c_in), .d_in(d_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .round_idx(round_idx),
        .c_out(c_out), .d_out(d_out), .done(done)
    );

    // Small parameter-sweep instance
    logic        start8, mode8, ready8;
    logic [7:0]  c8_in, d8_in, c8_out, d8_out;
    logic        busy8, valid8, done8;
    logic [2:0]  idx8;

    des_key_rotor #(.HALF_W(8), .ROUNDS(4), .SHIFT_MAP(4'b0110)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .c_in(c8_in), .d_in(d8_in),
        .busy(busy8), .out_valid(valid8), .out_ready(ready8), .round_idx(idx8),
        .c_out(c8_out), .d_out(d8_out), .done(done8)
    );

    // Reference model: round r output = rotl(X0, sum of shifts of rounds 1..r mod width)
    logic [27:0] ec [0:16];
    logic [27:0] ed [0:16];
    int          last_r;
    logic        last_md;

    function automatic logic [27:0] m_rotl(input logic [27:0] x, input int w, input int k);
        longint v, m;
        int     kk;
        kk = k % w;
        v  = longint'(x);
        m  = (64'd1 << w) - 1;
        return 28'(((v << kk) | (v >> (w - kk))) & m);
    endfunction

    task automatic build(input logic [15:0] map, input int w, input int nr,
                         input logic [27:0] c0, input logic [27:0] d0);
        int cum;
        cum = 0;
        for (int r = 1; r <= nr; r++) begin
            cum  += map[r-1] ? 2 : 1;
            ec[r] = m_rotl(c0, w, cum);
            ed[r] = m_rotl(d0, w, cum);
        end
    endtask

    // Runs one schedule on the DES instance; entered and left at a negedge.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random. poke_k: start pulse at that
    // handshake count. abort_k: reset asserted when that many handshakes are done.
    task automatic run_sched(input logic md, input logic [27:0] c, input logic [27:0] d,
                             input int rdy_mode, input int poke_k, input int abort_k);
        int   k, cyc, r;
        logic rdy;
        build(16'h7EFC, 28, 16, c, d);
        start = 1'b1; mode = md; c_in = c; d_in = d;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); c_in = 28'($urandom); d_in = 28'($urandom);
        k = 0; cyc = 0;
        while (k < 16 && cyc < 400) begin
            r = md ? 16 - k : k + 1;
            check_val("stream", {done, out_valid, busy, round_idx, c_out, d_out},
                      {1'b0, 1'b1, 1'b1, 5'(r), ec[r], ed[r]});
            if (abort_k == k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; out_ready = 1'b0;
                check_val("reset_mid", {done, out_valid, busy, round_idx, c_out, d_out}, 64'd0);
                return;
            end
            if (poke_k == k) begin
                start = 1'b1; mode = ~md; c_in = ~c; d_in = ~d;
            end else begin
                start = 1'b0;
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom);
            endcase
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        start = 1'b0;
        check_val("budget", 64'(k), 64'd16);
        last_r  = md ? 1 : 16;
        last_md = md;
        check_val("done_pulse", {done, out_valid, busy, round_idx, c_out, d_out},
                  {1'b1, 1'b0, 1'b0, 5'(last_r), ec[last_r], ed[last_r]});
        if (rdy_mode == 0)
            check_val("latency", 64'(cyc), 64'd16);
        out_ready = 1'($urandom);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_val("idle_hold", {done, out_valid, busy, round_idx, c_out, d_out},
                  {1'b0, 1'b0, 1'b0, 5'(last_r), ec[last_r], ed[last_r]});
    endtask

    // Schedule on the 8-bit instance; optional literal expectations for c_in=81 encrypt.
    task automatic run8(input logic md, input logic [7:0] c, input logic [7:0] d, input bit use_lit);
        logic [7:0] lit8 [0:3];
        int   k, cyc, r;
        logic rdy;
        lit8[0] = 8'h03; lit8[1] = 8'h0C; lit8[2] = 8'h30; lit8[3] = 8'h60;
        build(16'h0006, 8, 4, {20'd0, c}, {20'd0, d});
        start8 = 1'b1; mode8 = md; c8_in = c; d8_in = d;
        @(negedge clk);
        start8 = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 100) begin
            r = md ? 4 - k : k + 1;
            check_val("sweep_stream", {done8, valid8, busy8, idx8, c8_out, d8_out},
                      {1'b0, 1'b1, 1'b1, 3'(r), ec[r][7:0], ed[r][7:0]});
            if (use_lit)
                check_val("sweep_lit", {56'd0, c8_out}, {56'd0, lit8[r-1]});
            rdy = use_lit ? 1'b1 : 1'($urandom);
            ready8 = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        r = md ? 1 : 4;
        check_val("sweep_done", {done8, valid8, busy8, idx8, c8_out, d8_out},
                  {1'b1, 1'b0, 1'b0, 3'(r), ec[r][7:0], ed[r][7:0]});
        ready8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        c_in = '0; d_in = '0;
        start8 = 1'b0; mode8 = 1'b0; ready8 = 1'b0; c8_in = '0; d8_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("reset", {done, out_valid, busy, round_idx, c_out, d_out}, 64'd0);
        check_val("reset8", {done8, valid8, busy8, idx8, c8_out, d8_out}, 64'd0);

        run_sched(1'b0, 28'hF0CCAAF, 28'h556678F, 0, -1, -1);
        idle_check();
        run_sched(1'b1, 28'hF0CCAAF, 28'h556678F, 0, -1, -1);
        idle_check();
        run_sched(1'b0, 28'hF0CCAAF, 28'h556678F, 1, -1, -1);
        idle_check();
        run_sched(1'b0, 28'hF0CCAAF, 28'h556678F, 0, 5, -1);
        run_sched(1'b1, 28'($urandom), 28'($urandom), 2, -1, -1);
        idle_check();
        run_sched(1'b0, 28'hF0CCAAF, 28'h556678F, 0, -1, 6);
        run_sched(1'b0, 28'($urandom), 28'($urandom), 2, 3, -1);
        idle_check();
        for (int i = 0; i < 8; i++) begin
            run_sched(1'($urandom), 28'($urandom), 28'($urandom), 2, -1, -1);
            if ($urandom % 2 == 0) idle_check();
        end
        idle_check();

        run8(1'b0, 8'h81, 8'($urandom), 1'b1);
        run8(1'b1, 8'h81, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++)
            run8(1'($urandom), 8'($urandom), 8'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
